// File: rtl/bus_mux_n_to_1_reg.sv
// bus_mux_n_to_1_reg
// Parametrised N-source bus multiplexer with lowest-index priority,
// a same-cycle combinational bus, a registered bus copy, and sticky
// multi-driver contention detection with a saturating event counter.
// Optional macro BUS_HOLD_EN selects bus-keeper mode: with no enable set
// the registered bus holds its last value and the combinational bus shows
// it. Without the macro, an idle bus reads as zero.
module bus_mux_n_to_1_reg #(
   parameter int NUM_SRC = 22,
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 8,
   localparam int SEL_W  = $clog2(NUM_SRC)
) (
   input  logic                     clock,
   input  logic                     clear_n,
   input  logic [NUM_SRC-1:0]       src_en,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic                     err_clr,
   output logic [WIDTH-1:0]         bus_comb,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [SEL_W-1:0]         bus_src,
   output logic                     contention,
   output logic [CNT_W-1:0]         contention_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NUM_SRC-1:0] en_eff;
   logic               any_en;
   logic               multi_en;
   logic [SEL_W-1:0]   win_idx;
   logic [WIDTH-1:0]   win_data;

   logic [WIDTH-1:0]   bus_out_q,    bus_out_d;
   logic               bus_valid_q,  bus_valid_d;
   logic [SEL_W-1:0]   bus_src_q,    bus_src_d;
   logic               contention_q, contention_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;

   // Priority encode the enables (lowest index wins) and detect two or more drivers;
   // enables are ignored while in reset so the bus shows its idle value then.
   always_comb begin
      en_eff   = clear_n ? src_en : '0;
      any_en   = 1'b0;
      multi_en = 1'b0;
      win_idx  = '0;
      win_data = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (en_eff[i]) begin
            win_idx  = SEL_W'(i);
            win_data = src_data[i*WIDTH +: WIDTH];
         end
      end
      for (int j = 0; j < NUM_SRC; j++) begin
         if (en_eff[j]) begin
            if (any_en) begin
               multi_en = 1'b1;
            end
            any_en = 1'b1;
         end
      end
   end

   // Combinational bus: the winner's data, or the idle value when nobody drives.
   always_comb begin
      bus_comb = win_data;
      if (!any_en) begin
`ifdef BUS_HOLD_EN
         bus_comb = bus_out_q;
`else
         bus_comb = '0;
`endif
      end
   end

   // Next-state for the registered bus copy, winner index and valid flag.
   always_comb begin
      bus_valid_d = any_en;
      bus_out_d   = win_data;
      bus_src_d   = win_idx;
      if (!any_en) begin
`ifdef BUS_HOLD_EN
         bus_out_d = bus_out_q;
         bus_src_d = bus_src_q;
`else
         bus_out_d = '0;
         bus_src_d = '0;
`endif
      end
   end

   // Next-state for contention tracking; a new event beats a simultaneous clear.
   always_comb begin
      contention_d = contention_q;
      cnt_d        = cnt_q;
      if (multi_en) begin
         contention_d = 1'b1;
         if (err_clr) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (err_clr) begin
         contention_d = 1'b0;
         cnt_d        = '0;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         bus_out_q    <= '0;
         bus_valid_q  <= 1'b0;
         bus_src_q    <= '0;
         contention_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         bus_out_q    <= bus_out_d;
         bus_valid_q  <= bus_valid_d;
         bus_src_q    <= bus_src_d;
         contention_q <= contention_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus_out        = bus_out_q;
   assign bus_valid      = bus_valid_q;
   assign bus_src        = bus_src_q;
   assign contention     = contention_q;
   assign contention_cnt = cnt_q;

endmodule
